// File: rtl/muldiv_sequencer.sv
// Iterative signed multiply/divide sequencer owning the HI/LO registers.
// Shift/add multiply and restoring divide over WIDTH cycles, then a sign fix-up.
module muldiv_sequencer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CNT_W  = $clog2(WIDTH) + 1;
    localparam int unsigned RW     = WIDTH + 1;
    localparam int unsigned PW     = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t             state_q,  state_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic               op_q,     op_d;
    logic               rsign_q,  rsign_d;
    logic               dsign_q,  dsign_d;
    logic [WIDTH-1:0]   abs_a_q,  abs_a_d;
    logic [WIDTH-1:0]   abs_b_q,  abs_b_d;
    logic [PW-1:0]      prod_q,   prod_d;
    logic [RW-1:0]      rem_q,    rem_d;
    logic [WIDTH-1:0]   quo_q,    quo_d;
    logic               busy_q,   busy_d;
    logic               done_q,   done_d;
    logic               dz_q,     dz_d;
    logic [WIDTH-1:0]   hi_q,     hi_d;
    logic [WIDTH-1:0]   lo_q,     lo_d;

    logic [WIDTH-1:0]   abs_a_in, abs_b_in;
    logic [RW-1:0]      add_sum;
    logic [RW-1:0]      rem_shift, rem_trial;
    logic [PW-1:0]      prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    // Next-state, datapath step and output computation
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        rsign_d = rsign_q;
        dsign_d = dsign_q;
        abs_a_d = abs_a_q;
        abs_b_d = abs_b_q;
        prod_d  = prod_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dz_d    = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;

        // Most-negative operand maps to its unsigned magnitude naturally
        abs_a_in  = a[WIDTH-1] ? -a : a;
        abs_b_in  = b[WIDTH-1] ? -b : b;

        add_sum   = {1'b0, prod_q[PW-1:WIDTH]} + (prod_q[0] ? {1'b0, abs_a_q} : '0);
        rem_shift = (rem_q << 1) | RW'(quo_q[WIDTH-1]);
        rem_trial = rem_shift - {1'b0, abs_b_q};

        prod_fix  = rsign_q ? -prod_q : prod_q;
        quo_fix   = rsign_q ? -quo_q : quo_q;
        rem_fix   = dsign_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d    = op;
                    abs_a_d = abs_a_in;
                    abs_b_d = abs_b_in;
                    rsign_d = a[WIDTH-1] ^ b[WIDTH-1];
                    dsign_d = a[WIDTH-1];
                    cnt_d   = '0;
                    prod_d  = {{WIDTH{1'b0}}, abs_b_in};
                    rem_d   = '0;
                    quo_d   = abs_a_in;
                    if (op && (b == '0)) begin
                        done_d = 1'b1;
                        dz_d   = 1'b1;
                    end else begin
                        state_d = CALC;
                        busy_d  = 1'b1;
                    end
                end
            end
            CALC: begin
                if (op_q) begin
                    if (!rem_trial[WIDTH]) begin
                        rem_d = rem_trial;
                        quo_d = {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = rem_shift;
                        quo_d = {quo_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    prod_d = {add_sum, prod_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                if (op_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[PW-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers, synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= 1'b0;
            rsign_q <= 1'b0;
            dsign_q <= 1'b0;
            abs_a_q <= '0;
            abs_b_q <= '0;
            prod_q  <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            rsign_q <= rsign_d;
            dsign_q <= dsign_d;
            abs_a_q <= abs_a_d;
            abs_b_q <= abs_b_d;
            prod_q  <= prod_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = dz_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule
